// File: rtl/xnor_match_counter_if.sv
// Bus between the XNOR compare stage and the match counter:
// sample/clear controls in, lock state, totals and window reports out.
interface xnor_match_counter_if #(
   parameter int CNT_W  = 16,
   parameter int WINDOW = 16
);
   localparam int WERR_W = $clog2(WINDOW + 1);

   logic              m;
   logic              m_valid;
   logic              clr;
   logic              locked;
   logic [CNT_W-1:0]  match_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic              win_done;
   logic [WERR_W-1:0] win_errs;

   modport master (
      output m, m_valid, clr,
      input  locked, match_cnt, err_cnt, win_done, win_errs
   );

   modport slave (
      input  m, m_valid, clr,
      output locked, match_cnt, err_cnt, win_done, win_errs
   );
endinterface

// File: rtl/xnor_match_counter.sv
// Lock detector and error statistics for a bit-compare path: locks on a run
// of matches, then keeps saturating totals and per-window error reports.
module xnor_match_counter #(
   parameter int WINDOW    = 16,
   parameter int LOCK_RUN  = 8,
   parameter int LOSS_ERRS = 4,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic rst,
   xnor_match_counter_if.slave bus
);
   localparam int RUN_W  = $clog2(LOCK_RUN + 1);
   localparam int IDX_W  = $clog2(WINDOW);
   localparam int WERR_W = $clog2(WINDOW + 1);

   typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [RUN_W-1:0]  run_reg, run_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [WERR_W-1:0] werr_reg, werr_next;
   logic [WERR_W-1:0] werr_inc;
   logic [CNT_W-1:0]  match_cnt_reg, match_cnt_next;
   logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
   logic              win_done_reg, win_done_next;
   logic [WERR_W-1:0] win_errs_reg, win_errs_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_SEARCH;
         run_reg       <= '0;
         idx_reg       <= '0;
         werr_reg      <= '0;
         match_cnt_reg <= '0;
         err_cnt_reg   <= '0;
         win_done_reg  <= 1'b0;
         win_errs_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         run_reg       <= run_next;
         idx_reg       <= idx_next;
         werr_reg      <= werr_next;
         match_cnt_reg <= match_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         win_done_reg  <= win_done_next;
         win_errs_reg  <= win_errs_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      run_next       = run_reg;
      idx_next       = idx_reg;
      werr_next      = werr_reg;
      match_cnt_next = match_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      win_done_next  = 1'b0;
      win_errs_next  = win_errs_reg;
      werr_inc       = werr_reg + WERR_W'(!bus.m);

      // Clear only touches the reported values; lock tracking carries on.
      if (bus.clr) begin
         match_cnt_next = '0;
         err_cnt_next   = '0;
         win_errs_next  = '0;
      end

      if (bus.m_valid) begin
         case (state_reg)
            ST_SEARCH: begin
               if (!bus.m) begin
                  run_next = '0;
               end else if (run_reg == RUN_W'(LOCK_RUN - 1)) begin
                  state_next = ST_LOCKED;
                  run_next   = '0;
                  idx_next   = '0;
                  werr_next  = '0;
               end else begin
                  run_next = run_reg + RUN_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!bus.clr) begin
                  if (bus.m) begin
                     if (match_cnt_reg != {CNT_W{1'b1}})
                        match_cnt_next = match_cnt_reg + CNT_W'(1);
                  end else begin
                     if (err_cnt_reg != {CNT_W{1'b1}})
                        err_cnt_next = err_cnt_reg + CNT_W'(1);
                  end
               end
               // Loss takes priority over a window completing on the same sample.
               if (werr_inc == WERR_W'(LOSS_ERRS)) begin
                  state_next = ST_SEARCH;
                  run_next   = '0;
                  idx_next   = '0;
                  werr_next  = '0;
               end else if (idx_reg == IDX_W'(WINDOW - 1)) begin
                  win_done_next = 1'b1;
                  win_errs_next = bus.clr ? '0 : werr_inc;
                  idx_next      = '0;
                  werr_next     = '0;
               end else begin
                  idx_next  = idx_reg + IDX_W'(1);
                  werr_next = werr_inc;
               end
            end
            default: state_next = ST_SEARCH;
         endcase
      end
   end

   assign bus.locked    = (state_reg == ST_LOCKED);
   assign bus.match_cnt = match_cnt_reg;
   assign bus.err_cnt   = err_cnt_reg;
   assign bus.win_done  = win_done_reg;
   assign bus.win_errs  = win_errs_reg;
endmodule

// File: tb/tb_xnor_match_counter.sv
// Directed bench for xnor_match_counter: two instances (16-bit and 4-bit
// totals) share one stimulus stream and are checked against a reference model.
module tb_xnor_match_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, mv, m_drv, clr;

   xnor_match_counter_if #(.CNT_W(16), .WINDOW(16)) bus0 ();
   xnor_match_counter_if #(.CNT_W(4),  .WINDOW(16)) bus1 ();

   assign bus0.m = m_drv;
   assign bus0.m_valid = mv;
   assign bus0.clr = clr;
   assign bus1.m = m_drv;
   assign bus1.m_valid = mv;
   assign bus1.clr = clr;

   xnor_match_counter #(.WINDOW(16), .LOCK_RUN(8), .LOSS_ERRS(4), .CNT_W(16)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   xnor_match_counter #(.WINDOW(16), .LOCK_RUN(8), .LOSS_ERRS(4), .CNT_W(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: expected outputs per instance, from the behaviour rules.
   int cmax[2] = '{65535, 15};
   int e_locked[2], e_run[2], e_widx[2], e_werr[2];
   int e_match[2], e_err[2], e_wdone[2], e_werrs[2];
   bit model_ready = 1'b0;

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         e_wdone[k] = 0;
         if (rst) begin
            e_locked[k] = 0; e_run[k] = 0; e_widx[k] = 0; e_werr[k] = 0;
            e_match[k] = 0; e_err[k] = 0; e_werrs[k] = 0;
         end else begin
            if (clr) begin
               e_match[k] = 0; e_err[k] = 0; e_werrs[k] = 0;
            end
            if (mv && e_locked[k] == 0) begin
               e_run[k] = m_drv ? e_run[k] + 1 : 0;
               if (e_run[k] == 8) begin
                  e_locked[k] = 1; e_run[k] = 0; e_widx[k] = 0; e_werr[k] = 0;
               end
            end else if (mv) begin
               if (!clr) begin
                  if (m_drv) e_match[k] = (e_match[k] + 1 > cmax[k]) ? cmax[k] : e_match[k] + 1;
                  else       e_err[k]   = (e_err[k] + 1 > cmax[k]) ? cmax[k] : e_err[k] + 1;
               end
               e_widx[k] = e_widx[k] + 1;
               e_werr[k] = e_werr[k] + (m_drv ? 0 : 1);
               if (e_werr[k] == 4) begin
                  e_locked[k] = 0; e_run[k] = 0; e_widx[k] = 0; e_werr[k] = 0;
               end else if (e_widx[k] == 16) begin
                  e_wdone[k] = 1;
                  e_werrs[k] = clr ? 0 : e_werr[k];
                  e_widx[k] = 0; e_werr[k] = 0;
               end
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         model_ready = 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ready) begin
            chk("d0.locked", int'(bus0.locked), e_locked[0]);
            chk("d0.match_cnt", int'(bus0.match_cnt), e_match[0]);
            chk("d0.err_cnt", int'(bus0.err_cnt), e_err[0]);
            chk("d0.win_done", int'(bus0.win_done), e_wdone[0]);
            chk("d0.win_errs", int'(bus0.win_errs), e_werrs[0]);
            chk("d1.locked", int'(bus1.locked), e_locked[1]);
            chk("d1.match_cnt", int'(bus1.match_cnt), e_match[1]);
            chk("d1.err_cnt", int'(bus1.err_cnt), e_err[1]);
            chk("d1.win_done", int'(bus1.win_done), e_wdone[1]);
            chk("d1.win_errs", int'(bus1.win_errs), e_werrs[1]);
         end
      end
   end

   task automatic step(input logic r, input logic v, input logic mm, input logic c);
      rst = r; mv = v; m_drv = mm; clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      chk("rst.locked", int'(bus0.locked), 0);
      chk("rst.match_cnt", int'(bus0.match_cnt), 0);
      chk("rst.err_cnt", int'(bus0.err_cnt), 0);
      chk("rst.win_done", int'(bus0.win_done), 0);
      chk("rst.win_errs", int'(bus0.win_errs), 0);

      // Acquisition: 7 matches, error, 8 matches
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
      chk("acq.not_yet", int'(bus0.locked), 0);
      step(0, 1, 1, 0);
      chk("acq.locked", int'(bus0.locked), 1);
      chk("acq.match_cnt", int'(bus0.match_cnt), 0);
      chk("acq.err_cnt", int'(bus0.err_cnt), 0);

      // Window with errors at indices 3 and 10
      for (int i = 0; i < 16; i++) begin
         step(0, 1, (i != 3 && i != 10), 0);
         if (i == 14) chk("win.early_done", int'(bus0.win_done), 0);
      end
      chk("win.done", int'(bus0.win_done), 1);
      chk("win.win_errs", int'(bus0.win_errs), 2);
      chk("win.match_cnt", int'(bus0.match_cnt), 14);
      chk("win.err_cnt", int'(bus0.err_cnt), 2);
      chk("win.locked", int'(bus0.locked), 1);
      step(0, 0, 1, 0);
      chk("win.single_pulse", int'(bus0.win_done), 0);

      // Loss: 4 consecutive errors, then relock
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         chk("loss.no_done", int'(bus0.win_done), 0);
      end
      chk("loss.locked", int'(bus0.locked), 0);
      chk("loss.err_cnt", int'(bus0.err_cnt), 6);
      chk("loss.win_errs", int'(bus0.win_errs), 2);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
      chk("relock.locked", int'(bus0.locked), 1);
      chk("relock.match_cnt", int'(bus0.match_cnt), 14);
      chk("relock.err_cnt", int'(bus0.err_cnt), 6);

      // Gaps: M toggles with M_VALID low
      for (int i = 0; i < 10; i++) begin
         logic tog;
         tog = i[0];
         step(0, 0, tog, 0);
      end
      chk("gap.locked", int'(bus0.locked), 1);
      chk("gap.match_cnt", int'(bus0.match_cnt), 14);
      chk("gap.err_cnt", int'(bus0.err_cnt), 6);

      // Saturation on the 4-bit instance, then CLR with a valid error
      for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
      chk("sat.d1_match", int'(bus1.match_cnt), 15);
      chk("sat.d0_match", int'(bus0.match_cnt), 34);
      step(0, 1, 0, 1);
      chk("clr.d1_match", int'(bus1.match_cnt), 0);
      chk("clr.d1_err", int'(bus1.err_cnt), 0);
      chk("clr.d1_locked", int'(bus1.locked), 1);
      chk("clr.d0_err", int'(bus0.err_cnt), 0);

      // CLR on the window-completing sample
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
      step(0, 1, 0, 1);
      chk("clrwin.done", int'(bus0.win_done), 1);
      chk("clrwin.win_errs", int'(bus0.win_errs), 0);
      chk("clrwin.err_cnt", int'(bus0.err_cnt), 0);
      chk("clrwin.locked", int'(bus0.locked), 1);

      // Loss on the last sample of a window
      for (int i = 0; i < 15; i++) step(0, 1, (i != 2 && i != 7 && i != 11), 0);
      step(0, 1, 0, 0);
      chk("coinc.locked", int'(bus0.locked), 0);
      chk("coinc.no_done", int'(bus0.win_done), 0);
      chk("coinc.err_cnt", int'(bus0.err_cnt), 4);
      chk("coinc.match_cnt", int'(bus0.match_cnt), 12);

      // Reset mid-run discards progress
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
      step(1, 1, 1, 1);
      chk("midrst.match_cnt", int'(bus0.match_cnt), 0);
      chk("midrst.err_cnt", int'(bus0.err_cnt), 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
      chk("midrst.run_lost", int'(bus0.locked), 0);
      step(0, 1, 1, 0);
      chk("midrst.relock", int'(bus0.locked), 1);
      step(0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/xnor_match_counter.md
# xnor_match_counter

Sequential consumer of the per-bit XNOR equality result, i.e. 1 when received bit equals reference bit. Acquires lock on a run of consecutive matches. Once locked, it accumulates saturating match/error totals and reports per-window error counts. It drops lock when errors in one window reach a threshold. Sits directly downstream of the XNOR gate in the bit-compare path.

## Interface
- WINDOW, 16, valid bits per measurement window (>= 2)
- LOCK_RUN, 8, consecutive valid matches required to lock (>= 1)
- LOSS_ERRS, 4, errors within one window that force loss of lock (1..WINDOW)
- CNT_W, 16, width of total counters
- CLK  input  1  rising-edge clock, single clock domain
- RST  input  1  synchronous, active-high reset
- M  input  1  match bit from XNOR stage (1 = equal, 0 = error)
- M_VALID  input  1  M is sampled only when high
- CLR  input  1  synchronous clear of totals and WIN_ERRS
- LOCKED  output  1  high in LOCKED state
- MATCH_CNT  output  CNT_W  saturating count of valid matches while locked
- ERR_CNT  output  CNT_W  saturating count of valid errors while locked
- WIN_DONE  output  1  one-cycle pulse when a full window completes while locked
- WIN_ERRS  output  $clog2(WINDOW+1)  error count of last completed window

## Operation
- All outputs registered; RST forces state SEARCH and every output and internal counter to 0.
- A sample is a rising edge with M_VALID=1. Edges with M_VALID=0 change nothing, except RST and CLR.
- SEARCH state:
  - Run counter increments on a match and goes to 0 on an error.
  - When the run reaches LOCK_RUN, go to LOCKED. Run counter, window bit counter and window error counter are cleared.
  - Samples taken in SEARCH never touch MATCH_CNT/ERR_CNT.
- LOCKED state: each sample increments MATCH_CNT (M=1) or ERR_CNT (M=0), saturating at 2^CNT_W-1. The window bit counter advances 0..WINDOW-1. The window error counter adds 1 on an error.
- Loss of lock: when a sample brings the window error count to LOSS_ERRS, go to SEARCH.
  - That sample is counted in the totals.
  - Window counters and the run counter are cleared.
  - No WIN_DONE is issued. WIN_ERRS is unchanged.
- Window completion: on the sample at bit index WINDOW-1 without loss:
  - WIN_DONE pulses.
  - WIN_ERRS is loaded with the window's error count, including that sample.
  - Window counters restart at 0.
- If loss and window completion coincide on the same sample, loss wins.
- CLR zeroes MATCH_CNT, ERR_CNT and WIN_ERRS. It does not affect state, run or window counters.
  - If CLR coincides with a LOCKED sample, the clear wins and the sample is not added to the totals. The window counters still update.
  - If that sample completes the window, WIN_DONE still pulses and WIN_ERRS reads 0.
- RST overrides CLR and M_VALID.

## Timing
- Latency 1: the effects of a sample on the edge at cycle n are visible on the outputs in cycle n+1.
- LOCKED rises in the cycle after the LOCK_RUN-th consecutive match. That sample is not counted in the totals.
- LOCKED falls in the cycle after the LOSS_ERRS-th window error.
- WIN_DONE is high for exactly one cycle per completed window, even if M_VALID stays high.
- No throughput limit: one sample per cycle is sustained indefinitely.
- RST asserted mid-window or mid-run: all progress is discarded, and outputs are 0 in the next cycle.

## Test plan
- Reset: RST=1 for 2 cycles with M_VALID=1, M=1. Result: LOCKED=0, MATCH_CNT=ERR_CNT=0, WIN_DONE=0, WIN_ERRS=0.
- Acquisition (defaults): valid 7 matches, 1 error, 8 matches. Result: LOCKED rises the cycle after the 16th sample, MATCH_CNT=0, ERR_CNT=0.
- Window report: locked, then 16 valid samples with errors at indices 3 and 10. Result: WIN_DONE single pulse after the 16th sample, WIN_ERRS=2, MATCH_CNT=14, ERR_CNT=2, LOCKED stays 1.
- Loss: locked, then 4 consecutive errors. Result: LOCKED=0 after the 4th, ERR_CNT=4, no WIN_DONE. A further 8 matches relock with totals unchanged.
- Gaps: locked, M toggling with M_VALID=0 for 10 cycles. Result: no counter, state or WIN_DONE change.
- Saturation/CLR with CNT_W=4: locked, 20 matches gives MATCH_CNT=15. Then CLR together with a valid error gives MATCH_CNT=0, ERR_CNT=0, LOCKED=1.
